// File: rtl/pm_shift_ctrl.sv
`timescale 1ns/1ps
// pm_shift_ctrl
// Sequencer for CPU-initiated pixel-matrix shift operations. On an accepted
// start it presents a configured word on pm_din, emits cfg_cycles shift-clock
// pulses on pm_sclk (each phase lasting cfg_div+1 clk cycles), captures the
// matrix outputs at the end of each high phase, then finishes with a store
// strobe and a one-cycle done pulse.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, abort          one-cycle operation request / cancel
//   cfg_cycles            number of shift pulses (0 = store only)
//   cfg_div               phase length minus one, in clk cycles
//   cfg_din               word presented to the matrix
//   pm_din                matrix data input (held until next accepted start)
//   pm_dout_a, pm_dout_b  matrix outputs
//   pm_sclk, pm_store     matrix shift clock and store strobe
//   dout_a_q, dout_b_q    last captured matrix outputs
//   busy, done            operation in progress / completion pulse
module pm_shift_ctrl #(
  parameter int unsigned CNT_WIDTH = 16,
  parameter int unsigned DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] cfg_cycles,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [31:0]          cfg_din,
  output logic [31:0]          pm_din,
  input  logic [31:0]          pm_dout_a,
  input  logic [31:0]          pm_dout_b,
  output logic                 pm_sclk,
  output logic                 pm_store,
  output logic [31:0]          dout_a_q,
  output logic [31:0]          dout_b_q,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CLK_HIGH,
    CLK_LOW,
    STORE
  } state_t;

  state_t               state, state_nxt;
  logic [DIV_WIDTH-1:0] phase, phase_nxt;
  logic [DIV_WIDTH-1:0] div_s, div_s_nxt;
  logic [CNT_WIDTH-1:0] rem, rem_nxt, rem_dec;

  logic                 phase_last;
  logic                 accept;
  logic                 capture;

  logic                 sclk_nxt, store_nxt, busy_nxt, done_nxt;
  logic [31:0]          din_nxt;

  assign phase_last = (phase == div_s);
  assign accept     = (state == IDLE) && start && !abort;
  // Capture is suppressed on an aborting cycle so the last completed pulse's
  // data remains visible.
  assign capture    = (state == CLK_HIGH) && phase_last && !abort;
  assign rem_dec    = (rem != '0) ? rem - CNT_WIDTH'(1) : rem;

  // State register and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      div_s <= '0;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      div_s <= div_s_nxt;
      rem   <= rem_nxt;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = (cfg_cycles != '0) ? SETUP : STORE;
      SETUP:    if (phase_last) state_nxt = CLK_HIGH;
      CLK_HIGH: if (phase_last) state_nxt = (rem_dec == '0) ? STORE : CLK_LOW;
      CLK_LOW:  if (phase_last) state_nxt = CLK_HIGH;
      STORE:    if (phase_last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;

    // Phase counter restarts on every state change; no state follows itself
    // across a phase boundary, so a change of state marks the phase end.
    phase_nxt = ((state_nxt == state) && (state != IDLE)) ? phase + DIV_WIDTH'(1) : '0;

    rem_nxt = rem;
    if (accept)       rem_nxt = cfg_cycles;
    else if (capture) rem_nxt = rem_dec;

    div_s_nxt = accept ? cfg_div : div_s;
  end

  // Output logic: outputs are registered, so they are derived from the next state
  always_comb begin
    sclk_nxt  = (state_nxt == CLK_HIGH);
    store_nxt = (state_nxt == STORE);
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state == STORE) && (state_nxt == IDLE) && !abort;
    din_nxt   = accept ? cfg_din : pm_din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pm_din   <= '0;
      pm_sclk  <= 1'b0;
      pm_store <= 1'b0;
      dout_a_q <= '0;
      dout_b_q <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      pm_din   <= din_nxt;
      pm_sclk  <= sclk_nxt;
      pm_store <= store_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      if (capture) begin
        dout_a_q <= pm_dout_a;
        dout_b_q <= pm_dout_b;
      end
    end
  end

endmodule

// File: tb/tb_pm_shift_ctrl.sv
`timescale 1ns/1ps
module tb_pm_shift_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] cfg_cycles;
  logic [7:0]  cfg_div;
  logic [31:0] cfg_din;
  logic [31:0] pm_din;
  logic [31:0] pm_dout_a;
  logic [31:0] pm_dout_b;
  logic        pm_sclk;
  logic        pm_store;
  logic [31:0] dout_a_q;
  logic [31:0] dout_b_q;
  logic        busy;
  logic        done;

  pm_shift_ctrl #(.CNT_WIDTH(16), .DIV_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .cfg_cycles (cfg_cycles),
    .cfg_div    (cfg_div),
    .cfg_din    (cfg_din),
    .pm_din     (pm_din),
    .pm_dout_a  (pm_dout_a),
    .pm_dout_b  (pm_dout_b),
    .pm_sclk    (pm_sclk),
    .pm_store   (pm_store),
    .dout_a_q   (dout_a_q),
    .dout_b_q   (dout_b_q),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;

  // Reference state carried between operations
  logic [31:0] exp_a    = '0;
  logic [31:0] exp_b    = '0;
  logic [31:0] exp_din  = '0;
  bit          din_known = 1'b1;
  logic [31:0] a_base   = '0;
  logic [31:0] b_mask   = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one operation starting in the current (idle) cycle and checks every
  // cycle against a timeline computed from the cycle index: busy cycle t
  // belongs to phase segment (t-1)/(div+1); segment 0 is setup, odd segments
  // are sclk pulses, the final segment is the store. Returns in the done cycle
  // (or a few idle cycles after an abort) without advancing past it.
  task automatic run_op(input int n, input int div, input logic [31:0] din,
                        input int abort_t, input int extra_t, input string tag);
    int p, busy_len, seg, ph, j;
    logic e_busy, e_sclk, e_store, e_done;
    logic [31:0] cur_a, cur_b;
    logic [15:0] n16;
    logic [7:0]  d8;
    p        = div + 1;
    busy_len = (n == 0) ? p : (2 * n + 1) * p;
    n16 = n[15:0];
    d8  = div[7:0];
    cur_a = '0;
    cur_b = '0;
    cfg_cycles = n16;
    cfg_div    = d8;
    cfg_din    = din;
    start      = 1'b1;
    abort      = 1'b0;
    exp_din    = din;
    din_known  = (n != 0);
    tick();
    start = 1'b0;
    for (int t = 1; t <= busy_len + 1; t++) begin
      seg     = (t - 1) / p;
      ph      = (t - 1) % p;
      e_busy  = (t <= busy_len);
      e_done  = (t == busy_len + 1);
      e_store = e_busy && ((n == 0) || (seg == 2 * n));
      e_sclk  = e_busy && (n != 0) && (seg % 2 == 1);
      if (e_sclk) begin
        j     = (seg - 1) / 2;
        cur_a = a_base + 32'(j);
        cur_b = ~cur_a ^ b_mask;
        pm_dout_a = cur_a;
        pm_dout_b = cur_b;
      end else begin
        pm_dout_a = $urandom;
        pm_dout_b = $urandom;
      end
      if (e_busy) begin
        // Live config churns during the run; the operation must not notice.
        cfg_cycles = 16'($urandom);
        cfg_div    = 8'($urandom);
        cfg_din    = $urandom;
        start      = (t == extra_t);
      end else begin
        start = 1'b0;
      end
      abort = (t == abort_t);
      @(negedge clk);
      checks++;
      if (busy !== e_busy) begin
        failures++;
        $display("FAIL %s busy t=%0d got=%0b exp=%0b", tag, t, busy, e_busy);
      end
      checks++;
      if (pm_sclk !== e_sclk) begin
        failures++;
        $display("FAIL %s sclk t=%0d got=%0b exp=%0b", tag, t, pm_sclk, e_sclk);
      end
      checks++;
      if (pm_store !== e_store) begin
        failures++;
        $display("FAIL %s store t=%0d got=%0b exp=%0b", tag, t, pm_store, e_store);
      end
      checks++;
      if (done !== e_done) begin
        failures++;
        $display("FAIL %s done t=%0d got=%0b exp=%0b", tag, t, done, e_done);
      end
      if (din_known) begin
        checks++;
        if (pm_din !== exp_din) begin
          failures++;
          $display("FAIL %s pm_din t=%0d got=%h exp=%h", tag, t, pm_din, exp_din);
        end
      end
      checks++;
      if (dout_a_q !== exp_a || dout_b_q !== exp_b) begin
        failures++;
        $display("FAIL %s dout_q t=%0d got=%h/%h exp=%h/%h", tag, t, dout_a_q, dout_b_q, exp_a, exp_b);
      end
      if (t == abort_t) begin
        tick();
        abort = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++;
          if (busy !== 1'b0 || pm_sclk !== 1'b0 || pm_store !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s after_abort k=%0d got busy=%0b sclk=%0b store=%0b done=%0b exp all 0",
                     tag, k, busy, pm_sclk, pm_store, done);
          end
          checks++;
          if (dout_a_q !== exp_a || dout_b_q !== exp_b) begin
            failures++;
            $display("FAIL %s abort_hold k=%0d got=%h/%h exp=%h/%h", tag, k, dout_a_q, dout_b_q, exp_a, exp_b);
          end
          if (k < 2) tick();
        end
        return;
      end
      if (e_sclk && ph == p - 1) begin
        exp_a = cur_a;
        exp_b = cur_b;
      end
      if (!e_done) tick();
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; abort = 1'b0;
    cfg_cycles = '0; cfg_div = '0; cfg_din = '0;
    pm_dout_a = '0; pm_dout_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pm_din !== '0 || pm_sclk !== 1'b0 || pm_store !== 1'b0 || dout_a_q !== '0 ||
        dout_b_q !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got din=%h sclk=%0b store=%0b a=%h b=%h busy=%0b done=%0b exp all 0",
               pm_din, pm_sclk, pm_store, dout_a_q, dout_b_q, busy, done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    a_base = 32'h1000_0000;
    b_mask = '0;
    run_op(3, 0, 32'hA5A5_5A5A, 0, 0, "basic");
    checks++;
    if (dout_a_q !== 32'h1000_0002 || dout_b_q !== 32'hEFFF_FFFD) begin
      failures++;
      $display("FAIL basic_capture got=%h/%h exp=10000002/effffffd", dout_a_q, dout_b_q);
    end
    tick();
  endtask

  task automatic test_divider();
    a_base = $urandom; b_mask = $urandom;
    run_op(2, 3, $urandom, 0, 0, "divider");
    tick();
  endtask

  task automatic test_zero_count();
    a_base = $urandom; b_mask = $urandom;
    run_op(0, 2, $urandom, 0, 0, "zero_count");
    tick();
  endtask

  task automatic test_abort();
    a_base = 32'h2000_0000; b_mask = '0;
    // div=1: first cycle of the 4th high phase is segment 7, cycle 7*2+1
    run_op(10, 1, 32'h1234_5678, 15, 0, "abort");
    tick();
    run_op(10, 1, 32'h8765_4321, 0, 0, "abort_rerun");
    tick();
  endtask

  task automatic test_collisions();
    a_base = $urandom; b_mask = $urandom;
    run_op(4, 1, $urandom, 0, 5, "start_busy");
    tick();
    start = 1'b1; abort = 1'b1; cfg_cycles = 16'd3; cfg_div = '0; cfg_din = $urandom;
    tick();
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || pm_sclk !== 1'b0 || done !== 1'b0 ||
          (din_known && pm_din !== exp_din)) begin
        failures++;
        $display("FAIL start_abort_idle k=%0d got busy=%0b sclk=%0b done=%0b din=%h exp 0/0/0/%h",
                 k, busy, pm_sclk, done, pm_din, exp_din);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    a_base = $urandom; b_mask = $urandom;
    run_op(2, 0, $urandom, 0, 0, "b2b_first");
    run_op(3, 1, $urandom, 0, 0, "b2b_second");
    tick();
  endtask

  task automatic test_async_reset();
    cfg_cycles = 16'd5; cfg_div = 8'd1; cfg_din = 32'hDEAD_BEEF; start = 1'b1;
    pm_dout_a = 32'h5555_AAAA; pm_dout_b = 32'h3333_CCCC;
    tick();
    start = 1'b0;
    repeat (2) tick();
    // cycle 3: sclk high and a pulse has not yet been captured
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (pm_din !== '0 || pm_sclk !== 1'b0 || pm_store !== 1'b0 || dout_a_q !== '0 ||
        dout_b_q !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got din=%h sclk=%0b store=%0b a=%h b=%h busy=%0b done=%0b exp all 0",
               pm_din, pm_sclk, pm_store, dout_a_q, dout_b_q, busy, done);
    end
    tick();
    @(negedge clk);
    rst = 1'b0;
    exp_a = '0; exp_b = '0; exp_din = '0; din_known = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pm_sclk !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got busy=%0b done=%0b sclk=%0b exp 0/0/0", busy, done, pm_sclk);
    end
    a_base = $urandom; b_mask = $urandom;
    run_op(2, 0, $urandom, 0, 0, "post_reset_run");
    tick();
  endtask

  task automatic test_limits();
    a_base = $urandom; b_mask = $urandom;
    run_op(1, 255, $urandom, 0, 0, "max_div");
    tick();
    run_op(65535, 0, $urandom, 20, 0, "max_cycles");
    tick();
  endtask

  task automatic test_random();
    int n, div, p, bl, ab, ex, seg, ph;
    for (int i = 0; i < 25; i++) begin
      n   = $urandom_range(0, 6);
      div = $urandom_range(0, 3);
      p   = div + 1;
      bl  = (n == 0) ? p : (2 * n + 1) * p;
      ab  = 0;
      if ($urandom_range(0, 3) == 0) begin
        ab  = $urandom_range(1, bl);
        seg = (ab - 1) / p;
        ph  = (ab - 1) % p;
        if (n != 0 && seg % 2 == 1 && ph == p - 1) ab = 0;
      end
      ex = ($urandom_range(0, 1) == 1) ? $urandom_range(1, bl) : 0;
      if (ab != 0 && ex > ab) ex = 0;
      a_base = $urandom;
      b_mask = $urandom;
      run_op(n, div, $urandom, ab, ex, "random");
      repeat ($urandom_range(0, 2)) tick();
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_divider();
    test_zero_count();
    test_abort();
    test_collisions();
    test_back_to_back();
    test_async_reset();
    test_limits();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
